tl_phase_scheduler: RTL and testbench

- Request-driven phase sequencer for the three-way light set: J (main road), P (pedestrian), C (cross road).
- Latches pedestrian and cross-road requests and holds J by default.
- Serves only the requested phases, each followed by a timed clearance (yellow) interval.
- Produces the J/P/C enables plus a clearance flag for the lamp drivers; all timing derives from a 1-second tick prescaled from clk.

---
 rtl/tl_phase_scheduler.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_tl_phase_scheduler.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tl_phase_scheduler.sv
// -----------------------------------------------------------------------------
// tl_phase_scheduler
//
// Request-driven phase sequencer for a three-way light set:
//   J = main road, P = pedestrian crossing, C = cross road.
// J is held green by default. Pedestrian and cross-road requests are latched.
// Only the phases that have been requested are served, and each green phase is
// followed by a timed clearance (yellow) interval. All timing comes from a
// one-second tick, which is prescaled from clk.
//
// Optional feature (compile-time macro TL_ALLRED_EN):
//   When the macro is defined, every clearance interval is followed by an
//   all-red interval lasting AR seconds. During all-red, J = P = C = 0 and
//   yel = 0. The sequencer then continues to the destination phase that was
//   chosen when the clearance interval ended.
//   When the macro is undefined, a clearance goes straight to the next green.
//
// Ports:
//   clk     in   system clock
//   rst     in   synchronous, active-low reset
//   req_p   in   pedestrian button (level or single-cycle pulse)
//   req_c   in   cross-road vehicle sensor (level or single-cycle pulse)
//   N       in   manual advance, single-cycle pulse
//   J       out  main-road enable (J green and J clearance)
//   P       out  pedestrian enable (P green and P clearance)
//   C       out  cross-road enable (C green and C clearance)
//   yel     out  high in any clearance state
//   sec     out  whole seconds elapsed in the current state
//   busy_p  out  pedestrian request pending
//   busy_c  out  cross-road request pending
// -----------------------------------------------------------------------------
module tl_phase_scheduler #(
    parameter int UCY   = 1000,
    parameter int J_MIN = 10,
    parameter int P_GO  = 7,
    parameter int C_GO  = 16,
    parameter int CLR   = 3,
`ifdef TL_ALLRED_EN
    parameter int AR    = 1,
`endif
    parameter int CW    = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_p,
    input  logic          req_c,
    input  logic          N,
    output logic          J,
    output logic          P,
    output logic          C,
    output logic          yel,
    output logic [CW-1:0] sec,
    output logic          busy_p,
    output logic          busy_c
);

    typedef enum logic [2:0] {
        S_J_GO  = 3'd0,
        S_J_CLR = 3'd1,
        S_P_GO  = 3'd2,
        S_P_CLR = 3'd3,
        S_C_GO  = 3'd4,
        S_C_CLR = 3'd5
`ifdef TL_ALLRED_EN
        , S_AR  = 3'd6
`endif
    } state_t;

    // Each "last second" value is the sec count on which the final tick of a
    // timed state lands. This makes every timed state last exactly dur*UCY
    // clocks.
    localparam logic [CW-1:0] UCY_LAST = CW'(UCY - 1);
    localparam logic [CW-1:0] J_MIN_W  = CW'(J_MIN);
    localparam logic [CW-1:0] J_LAST   = CW'(J_MIN - 1);
    localparam logic [CW-1:0] P_LAST   = CW'(P_GO - 1);
    localparam logic [CW-1:0] C_LAST   = CW'(C_GO - 1);
    localparam logic [CW-1:0] CLR_LAST = CW'(CLR - 1);
`ifdef TL_ALLRED_EN
    localparam logic [CW-1:0] AR_LAST  = CW'(AR - 1);
`endif
    localparam logic [CW-1:0] SEC_MAX  = {CW{1'b1}};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

    state_t        state_r;
    state_t        state_s;
    state_t        clr_dest_s;
`ifdef TL_ALLRED_EN
    state_t        ar_dest_r;
    state_t        ar_dest_s;
`endif
    logic [CW-1:0] presc_r;
    logic [CW-1:0] sec_r;
    logic          tick_s;
    logic          clr_done_s;
    logic          sec_inc_s;
    logic          busy_p_r;
    logic          busy_c_r;
    logic          busy_p_s;
    logic          busy_c_s;
    logic          j_r;
    logic          p_r;
    logic          c_r;
    logic          yel_r;

    // Lamp pattern {J, P, C, yel} for a state. Unknown encodings fall back to
    // the J pattern, because the next-state logic recovers to J_GO.
    function automatic logic [3:0] lamp_of(input state_t s);
        logic [3:0] l;
        case (s)
            S_J_GO:  l = 4'b1000;
            S_J_CLR: l = 4'b1001;
            S_P_GO:  l = 4'b0100;
            S_P_CLR: l = 4'b0101;
            S_C_GO:  l = 4'b0010;
            S_C_CLR: l = 4'b0011;
`ifdef TL_ALLRED_EN
            S_AR:    l = 4'b0000;
`endif
            default: l = 4'b1000;
        endcase
        return l;
    endfunction

    assign tick_s     = (presc_r == UCY_LAST);
    assign clr_done_s = tick_s && (sec_r == CLR_LAST);

    assign J      = j_r;
    assign P      = p_r;
    assign C      = c_r;
    assign yel    = yel_r;
    assign sec    = sec_r;
    assign busy_p = busy_p_r;
    assign busy_c = busy_c_r;

    // Pick the phase that follows the current clearance interval.
    always_comb begin
        case (state_r)
            S_J_CLR: clr_dest_s = busy_p_r ? S_P_GO : S_C_GO;
            S_P_CLR: clr_dest_s = busy_c_r ? S_C_GO : S_J_GO;
            default: clr_dest_s = S_J_GO;
        endcase
    end

    // Next-state logic. N (manual advance) takes priority over timed exits.
    always_comb begin
        state_s = state_r;
`ifdef TL_ALLRED_EN
        ar_dest_s = ar_dest_r;
`endif
        case (state_r)
            S_J_GO: begin
                // Leave J_GO only when a request is pending. If the request
                // was already pending, the exit falls on the tick that
                // completes J_MIN. Otherwise the exit happens one clock after
                // the request latch is set.
                if ((busy_p_r || busy_c_r) &&
                    ((sec_r >= J_MIN_W) || (tick_s && (sec_r == J_LAST)))) begin
                    state_s = S_J_CLR;
                end else begin
                    state_s = S_J_GO;
                end
            end
            S_P_GO: begin
                if (N || (tick_s && (sec_r == P_LAST))) begin
                    state_s = S_P_CLR;
                end else begin
                    state_s = S_P_GO;
                end
            end
            S_C_GO: begin
                if (N || (tick_s && (sec_r == C_LAST))) begin
                    state_s = S_C_CLR;
                end else begin
                    state_s = S_C_GO;
                end
            end
            S_J_CLR, S_P_CLR, S_C_CLR: begin
                if (clr_done_s) begin
`ifdef TL_ALLRED_EN
                    state_s   = S_AR;
                    ar_dest_s = clr_dest_s;
`else
                    state_s   = clr_dest_s;
`endif
                end else begin
                    state_s = state_r;
                end
            end
`ifdef TL_ALLRED_EN
            S_AR: begin
                if (tick_s && (sec_r == AR_LAST)) begin
                    state_s = ar_dest_r;
                end else begin
                    state_s = S_AR;
                end
            end
`endif
            default: state_s = S_J_GO;
        endcase
    end

    // Request latches. Entering a green phase clears that phase's latch, and
    // this clear overrides a set arriving on the same edge. A request for the
    // phase that is currently being served is ignored.
    always_comb begin
        busy_p_s = busy_p_r;
        busy_c_s = busy_c_r;
        if (req_p && (state_r != S_P_GO) && (state_r != S_P_CLR)) begin
            busy_p_s = 1'b1;
        end else begin
            busy_p_s = busy_p_r;
        end
        if ((req_c && (state_r != S_C_GO) && (state_r != S_C_CLR)) ||
            (N && (state_r == S_J_GO))) begin
            busy_c_s = 1'b1;
        end else begin
            busy_c_s = busy_c_c_hold();
        end
        if ((state_s == S_P_GO) && (state_r != S_P_GO)) begin
            busy_p_s = 1'b0;
        end else begin
            busy_p_s = busy_p_s;
        end
        if ((state_s == S_C_GO) && (state_r != S_C_GO)) begin
            busy_c_s = 1'b0;
        end else begin
            busy_c_s = busy_c_s;
        end
    end

    // Current value of the cross-road latch, used when nothing sets it.
    function automatic logic busy_c_c_hold();
        return busy_c_r;
    endfunction

    // The seconds counter stops at J_MIN while in J_GO, and saturates at its
    // maximum value everywhere else.
    always_comb begin
        if (tick_s && (sec_r != SEC_MAX) &&
            !((state_r == S_J_GO) && (sec_r >= J_MIN_W))) begin
            sec_inc_s = 1'b1;
        end else begin
            sec_inc_s = 1'b0;
        end
    end

    // State, timing counters, request latches and registered lamp outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r  <= S_J_GO;
`ifdef TL_ALLRED_EN
            ar_dest_r <= S_J_GO;
`endif
            presc_r  <= '0;
            sec_r    <= '0;
            busy_p_r <= 1'b0;
            busy_c_r <= 1'b0;
            j_r      <= 1'b1;
            p_r      <= 1'b0;
            c_r      <= 1'b0;
            yel_r    <= 1'b0;
        end else begin
            state_r  <= state_s;
`ifdef TL_ALLRED_EN
            ar_dest_r <= ar_dest_s;
`endif
            busy_p_r <= busy_p_s;
            busy_c_r <= busy_c_s;
            {j_r, p_r, c_r, yel_r} <= lamp_of(state_s);
            if (state_s != state_r) begin
                // Every state starts from a fresh second boundary.
                presc_r <= '0;
                sec_r   <= '0;
            end else begin
                if (tick_s) begin
                    presc_r <= '0;
                end else begin
                    presc_r <= presc_r + CNT_ONE;
                end
                if (sec_inc_s) begin
                    sec_r <= sec_r + CNT_ONE;
                end else begin
                    sec_r <= sec_r;
                end
            end
        end
    end

endmodule

// File: tb/tb_tl_phase_scheduler.sv
// -----------------------------------------------------------------------------
// tb_tl_phase_scheduler
//
// Self-checking bench for tl_phase_scheduler, with UCY=4 and J_MIN=3.
// Each scenario pushes the expected lamp segments ({J,P,C,yel} and duration
// in clocks) onto a scoreboard queue, then drives its stimulus. It pops one
// expected segment each time the DUT finishes a segment, and compares them.
// Clocks are counted from the reset edge (clock 0).
// When TL_ALLRED_EN is defined, 4-clock all-red segments are expected after
// every clearance interval.
// -----------------------------------------------------------------------------
module tb_tl_phase_scheduler;

    localparam int CW = 12;

    localparam logic [3:0] L_J   = 4'b1000;
    localparam logic [3:0] L_JC  = 4'b1001;
    localparam logic [3:0] L_P   = 4'b0100;
    localparam logic [3:0] L_PC  = 4'b0101;
    localparam logic [3:0] L_C   = 4'b0010;
    localparam logic [3:0] L_CC  = 4'b0011;
    localparam logic [3:0] L_AR  = 4'b0000;
`ifdef TL_ALLRED_EN
    localparam int AR_CLKS = 4;
`else
    localparam int AR_CLKS = 0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req_p = 1'b0;
    logic          req_c = 1'b0;
    logic          N = 1'b0;
    logic          J;
    logic          P;
    logic          C;
    logic          yel;
    logic [CW-1:0] sec;
    logic          busy_p;
    logic          busy_c;

    typedef struct {
        logic [3:0] lamp;
        int         len;
    } seg_t;

    seg_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    tl_phase_scheduler #(
        .UCY(4), .J_MIN(3), .P_GO(7), .C_GO(16), .CLR(3), .CW(CW)
    ) dut (
        .clk(clk), .rst(rst), .req_p(req_p), .req_c(req_c), .N(N),
        .J(J), .P(P), .C(C), .yel(yel), .sec(sec),
        .busy_p(busy_p), .busy_c(busy_c)
    );

    // Push one expected segment, and an all-red segment after it when the
    // segment is a clearance interval and all-red is enabled.
    task automatic push_seg(input logic [3:0] lamp, input int len);
        seg_t s;
        s.lamp = lamp;
        s.len  = len;
        exp_q.push_back(s);
        if (AR_CLKS > 0 && lamp[0] == 1'b1) begin
            s.lamp = L_AR;
            s.len  = AR_CLKS;
            exp_q.push_back(s);
        end
    endtask

    // Called on a negedge at the start of a segment. Returns that segment's
    // pattern and its length in clocks, and leaves the bench on the first
    // negedge of the next segment. The length is capped at 400 clocks.
    task automatic measure(output logic [3:0] lamp, output int len);
        logic [3:0] first;
        first = {J, P, C, yel};
        len = 0;
        while ({J, P, C, yel} == first && len < 400) begin
            @(negedge clk);
            len++;
        end
        lamp = first;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst   = 1'b0;
        req_p = 1'b0;
        req_c = 1'b0;
        N     = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({J, P, C, yel, busy_p, busy_c} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_outputs: got %b, want 100000", {J, P, C, yel, busy_p, busy_c});
        end
        checks++;
        if (sec !== 12'd0) begin
            errors++;
            $display("FAIL reset_sec: got %0d, want 0", sec);
        end
    endtask

    task automatic test_hold_j();
        do_reset();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            checks++;
            if ({J, P, C, yel} !== L_J) begin
                errors++;
                $display("FAIL hold_j_lamp cycle %0d: got %b, want %b", i, {J, P, C, yel}, L_J);
            end
        end
        checks++;
        if (sec !== 12'd3) begin
            errors++;
            $display("FAIL hold_j_sec: got %0d, want 3", sec);
        end
    endtask

    task automatic test_ped();
        seg_t e;
        logic [3:0] lamp;
        int len;
        do_reset();
        push_seg(L_J, 12);
        push_seg(L_JC, 12);
        push_seg(L_P, 28);
        push_seg(L_PC, 12);
        fork
            begin
                while (exp_q.size() > 0) begin
                    measure(lamp, len);
                    e = exp_q.pop_front();
                    checks++;
                    if (lamp !== e.lamp || len != e.len) begin
                        errors++;
                        $display("FAIL ped_seg: got lamp %b len %0d, want lamp %b len %0d", lamp, len, e.lamp, e.len);
                    end
                end
            end
            begin
                @(negedge clk); req_p = 1'b1;
                @(negedge clk); req_p = 1'b0;
                // Pulse again during P_GO; it must be ignored.
                repeat (28) @(negedge clk);
                req_p = 1'b1;
                @(negedge clk); req_p = 1'b0;
            end
        join
        checks++;
        if ({J, P, C, yel, busy_p, busy_c} !== 6'b100000 || sec !== 12'd0) begin
            errors++;
            $display("FAIL ped_return: got %b sec %0d, want 100000 sec 0", {J, P, C, yel, busy_p, busy_c}, sec);
        end
        repeat (20) @(negedge clk);
        checks++;
        if ({J, P, C, yel} !== L_J) begin
            errors++;
            $display("FAIL ped_stay_j: got %b, want %b", {J, P, C, yel}, L_J);
        end
    endtask

    task automatic test_both();
        seg_t e;
        logic [3:0] lamp;
        int len;
        do_reset();
        push_seg(L_J, 12);
        push_seg(L_JC, 12);
        push_seg(L_P, 28);
        push_seg(L_PC, 12);
        push_seg(L_C, 64);
        push_seg(L_CC, 12);
        fork
            begin
                while (exp_q.size() > 0) begin
                    measure(lamp, len);
                    e = exp_q.pop_front();
                    checks++;
                    if (lamp !== e.lamp || len != e.len) begin
                        errors++;
                        $display("FAIL both_seg: got lamp %b len %0d, want lamp %b len %0d", lamp, len, e.lamp, e.len);
                    end
                    if ({J, P, C, yel} == L_P) begin
                        checks++;
                        if ({busy_p, busy_c} !== 2'b01) begin
                            errors++;
                            $display("FAIL both_busy_at_p: got %b, want 01", {busy_p, busy_c});
                        end
                    end
                    if ({J, P, C, yel} == L_C) begin
                        checks++;
                        if ({busy_p, busy_c} !== 2'b00) begin
                            errors++;
                            $display("FAIL both_busy_at_c: got %b, want 00", {busy_p, busy_c});
                        end
                    end
                end
            end
            begin
                @(negedge clk); req_p = 1'b1; req_c = 1'b1;
                @(negedge clk); req_p = 1'b0; req_c = 1'b0;
            end
        join
        checks++;
        if ({J, P, C, yel, busy_p, busy_c} !== 6'b100000) begin
            errors++;
            $display("FAIL both_return: got %b, want 100000", {J, P, C, yel, busy_p, busy_c});
        end
    endtask

    task automatic test_n_skip();
        seg_t e;
        logic [3:0] lamp;
        int len;
        int c_start;
        c_start = 24 + AR_CLKS;
        do_reset();
        push_seg(L_J, 12);
        push_seg(L_JC, 12);
        push_seg(L_C, 5);
        push_seg(L_CC, 12);
        fork
            begin
                while (exp_q.size() > 0) begin
                    measure(lamp, len);
                    e = exp_q.pop_front();
                    checks++;
                    if (lamp !== e.lamp || len != e.len) begin
                        errors++;
                        $display("FAIL nskip_seg: got lamp %b len %0d, want lamp %b len %0d", lamp, len, e.lamp, e.len);
                    end
                end
            end
            begin
                @(negedge clk); req_c = 1'b1;
                @(negedge clk); req_c = 1'b0;
                // N is sampled on clock 5 of C_GO.
                repeat (c_start + 4 - 2) @(negedge clk);
                N = 1'b1;
                @(negedge clk); N = 1'b0;
                // A second N pulse during C_CLR must be ignored.
                repeat (3) @(negedge clk);
                N = 1'b1;
                @(negedge clk); N = 1'b0;
            end
        join
        checks++;
        if ({J, P, C, yel, busy_c} !== 5'b10000) begin
            errors++;
            $display("FAIL nskip_return: got %b, want 10000", {J, P, C, yel, busy_c});
        end
    endtask

    task automatic test_n_jgo();
        seg_t e;
        logic [3:0] lamp;
        int len;
        do_reset();
        push_seg(L_J, 12);
        push_seg(L_JC, 12);
        push_seg(L_C, 64);
        fork
            begin
                while (exp_q.size() > 0) begin
                    measure(lamp, len);
                    e = exp_q.pop_front();
                    checks++;
                    if (lamp !== e.lamp || len != e.len) begin
                        errors++;
                        $display("FAIL njgo_seg: got lamp %b len %0d, want lamp %b len %0d", lamp, len, e.lamp, e.len);
                    end
                end
            end
            begin
                @(negedge clk); N = 1'b1;
                @(negedge clk); N = 1'b0;
                checks++;
                if ({busy_p, busy_c} !== 2'b01) begin
                    errors++;
                    $display("FAIL njgo_busy: got %b, want 01", {busy_p, busy_c});
                end
            end
        join
        checks++;
        if ({J, P, C, yel} !== L_CC) begin
            errors++;
            $display("FAIL njgo_after_c: got %b, want %b", {J, P, C, yel}, L_CC);
        end
    endtask

    task automatic test_late();
        seg_t e;
        logic [3:0] lamp;
        int len;
        do_reset();
        push_seg(L_J, 22);
        push_seg(L_JC, 12);
        push_seg(L_P, 28);
        fork
            begin
                while (exp_q.size() > 0) begin
                    measure(lamp, len);
                    e = exp_q.pop_front();
                    checks++;
                    if (lamp !== e.lamp || len != e.len) begin
                        errors++;
                        $display("FAIL late_seg: got lamp %b len %0d, want lamp %b len %0d", lamp, len, e.lamp, e.len);
                    end
                end
            end
            begin
                repeat (20) @(negedge clk);
                req_p = 1'b1;
                @(negedge clk); req_p = 1'b0;
            end
        join
    endtask

    task automatic test_reset_mid();
        seg_t e;
        logic [3:0] lamp;
        int len;
        do_reset();
        push_seg(L_J, 12);
        push_seg(L_JC, 12);
        fork
            begin
                while (exp_q.size() > 0) begin
                    measure(lamp, len);
                    e = exp_q.pop_front();
                    checks++;
                    if (lamp !== e.lamp || len != e.len) begin
                        errors++;
                        $display("FAIL rmid_seg: got lamp %b len %0d, want lamp %b len %0d", lamp, len, e.lamp, e.len);
                    end
                end
            end
            begin
                @(negedge clk); req_p = 1'b1; req_c = 1'b1;
                @(negedge clk); req_p = 1'b0; req_c = 1'b0;
            end
        join
        checks++;
        if ({J, P, C, yel, busy_c} !== 5'b01001) begin
            errors++;
            $display("FAIL rmid_in_p: got %b, want 01001", {J, P, C, yel, busy_c});
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        checks++;
        if ({J, P, C, yel, busy_p, busy_c} !== 6'b100000 || sec !== 12'd0) begin
            errors++;
            $display("FAIL rmid_after_rst: got %b sec %0d, want 100000 sec 0", {J, P, C, yel, busy_p, busy_c}, sec);
        end
    endtask

    initial begin
        test_reset();
        test_hold_j();
        test_ped();
        test_both();
        test_n_skip();
        test_n_jgo();
        test_late();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
